// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-coded sequence receiver.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } gseq_state_t;

  localparam int unsigned GRAY_MAX_W = 32;

  // Fixed-width Gray-to-binary decode; narrower values are zero-extended by the caller.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned k = 1; k < GRAY_MAX_W; k++) begin
      b[GRAY_MAX_W-1-k] = b[GRAY_MAX_W-k] ^ g[GRAY_MAX_W-1-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_decoder_g2b.sv
// Combinational Gray-to-binary decoder, MSB-first XOR chain.
module gray_to_bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      bin_o[WIDTH-1-k] = bin_o[WIDTH-k] ^ gray_i[WIDTH-1-k];
    end
  end

endmodule

// File: rtl/gray_seq_decoder.sv
// Receive side of the modulo-N sequence link: decodes Gray samples, tracks
// +1 mod N progression, locks after LOCK_COUNT good steps, flags breaks.
module gray_seq_decoder
  import gray_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned MODULUS    = 5,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERRW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             locked,
  output logic             seq_err,
  output logic [ERRW-1:0]  err_count
);

  localparam int unsigned     CW     = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH:0]  MOD_W  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]  LAST_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [CW-1:0]   LOCK_W = CW'(LOCK_COUNT);
  localparam logic [CW-1:0]   ONE_W  = CW'(1);

  gseq_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             seq_err_d;

  logic [WIDTH-1:0] dec;
  logic             in_range;
  logic             good;
  logic [WIDTH-1:0] next_exp;
  logic [CW-1:0]    cnt_inc;

  gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
    .gray_i (gray_in),
    .bin_o  (dec)
  );

  // Sample classification; MODULUS = 2**WIDTH wraps via natural WIDTH-bit overflow.
  always_comb begin
    in_range = {1'b0, dec} < MOD_W;
    good     = in_range && (dec == exp_q);
    next_exp = ({1'b0, dec} == LAST_W) ? '0 : dec + WIDTH'(1);
    cnt_inc  = cnt_q + ONE_W;
  end

  // Next-state: sequence tracking FSM, expected value and saturating error count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    err_d     = err_q;
    seq_err_d = 1'b0;
    if (in_valid) begin
      if (in_range) exp_d = next_exp;
      unique case (state_q)
        HUNT: begin
          if (in_range) begin
            state_d = SYNC;
            cnt_d   = ONE_W;
          end
        end
        SYNC: begin
          if (good) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_W) state_d = LOCKED;
          end else if (in_range) begin
            cnt_d = ONE_W;
          end else begin
            state_d = HUNT;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            seq_err_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERRW'(1);
            if (in_range) begin
              state_d = SYNC;
              cnt_d   = ONE_W;
            end else begin
              state_d = HUNT;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      exp_q     <= '0;
      err_q     <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
      locked    <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      out_valid <= in_valid;
      if (in_valid) bin_out <= dec;
      locked    <= (state_d == LOCKED);
      seq_err   <= seq_err_d;
    end
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Self-checking bench for gray_seq_decoder (WIDTH=3, MODULUS=5, LOCK_COUNT=3).
module tb_gray_seq_decoder;

  localparam int unsigned W   = 3;
  localparam int unsigned MOD = 5;
  localparam int unsigned LC  = 3;
  localparam int unsigned EW  = 8;
  localparam int unsigned SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic          out_valid;
  logic [W-1:0]  bin_out;
  logic          locked;
  logic          seq_err;
  logic [EW-1:0] err_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: expected next index, length of current good run, error tally.
  int unsigned m_exp, m_run, m_err, m_bin;
  bit          m_vld, m_seqerr;

  gray_seq_decoder #(
    .WIDTH      (W),
    .MODULUS    (MOD),
    .LOCK_COUNT (LC),
    .ERRW       (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .locked    (locked),
    .seq_err   (seq_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    check({ctx, ".bin_out"},   32'(bin_out),   m_bin);
    check({ctx, ".locked"},    32'(locked),    32'(m_run >= LC));
    check({ctx, ".seq_err"},   32'(seq_err),   32'(m_seqerr));
    check({ctx, ".err_count"}, 32'(err_count), m_err);
  endtask

  task automatic model_reset();
    m_exp = 0; m_run = 0; m_err = 0; m_bin = 0; m_vld = 0; m_seqerr = 0;
  endtask

  // Apply one cycle of input (binary index b sent as Gray), then compare.
  task automatic step(input bit v, input int unsigned b, input string ctx);
    bit inr, good;
    in_valid = v;
    gray_in  = W'(b ^ (b >> 1));
    @(posedge clk);
    #1;
    m_vld = v;
    m_seqerr = 0;
    if (v) begin
      m_bin = b;
      inr  = (b < MOD);
      good = inr && (b == m_exp);
      if (m_run >= LC && !good) begin
        m_seqerr = 1;
        if (m_err < SAT) m_err++;
      end
      if (!inr)                     m_run = 0;
      else if (good && m_run > 0)   m_run = (m_run + 1 > LC) ? LC : m_run + 1;
      else                          m_run = 1;
      if (inr) m_exp = (b + 1) % MOD;
    end
    check_all(ctx);
    in_valid = 1'b0;
  endtask

  task automatic apply_reset(input string ctx);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int unsigned r, b;
    bit v;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b1;

    // 1: acquire lock on 0,1,2
    step(1, 0, "s1a"); step(1, 1, "s1b"); step(1, 2, "s1c");
    check("s1.locked_const", 32'(locked), 32'd1);
    // 2: continue through wrap
    step(1, 3, "s2a"); step(1, 4, "s2b"); step(1, 0, "s2c"); step(1, 1, "s2d");
    step(1, 2, "s2e");
    // 3: repeated sample while locked, then relock
    step(1, 2, "s3a");
    check("s3.seq_err_const", 32'(seq_err), 32'd1);
    step(1, 3, "s3b"); step(1, 4, "s3c");
    check("s3.err_const", 32'(err_count), 32'd1);
    // 4: out-of-range sample while locked, ignored value, restart
    step(1, 5, "s4a"); step(1, 7, "s4b"); step(1, 0, "s4c"); step(0, 0, "s4d");
    step(1, 1, "s4e"); step(1, 2, "s4f");
    // 5: drive the error counter into saturation
    for (int k = 0; k < 260; k++) begin
      step(1, (m_exp + 2) % MOD, "s5err");
      step(1, m_exp, "s5r1");
      step(1, m_exp, "s5r2");
    end
    check("s5.sat_const", 32'(err_count), SAT);
    // 6: reset mid-stream, then lock with gaps in valid
    apply_reset("s6rst");
    step(1, 0, "s6a"); step(0, 0, "s6b"); step(1, 1, "s6c"); step(0, 0, "s6d");
    step(0, 0, "s6e"); step(1, 2, "s6f"); step(1, 3, "s6g");
    step(1, 0, "s6h"); step(1, 1, "s6i"); step(1, 2, "s6j"); step(1, 0, "s6k");
    apply_reset("s6rst2");

    // Randomised traffic: mostly in-sequence, with repeats, gaps and arbitrary values.
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       b = m_exp;
      else if (r == 7) b = (m_exp + MOD - 1) % MOD;
      else             b = $urandom_range(0, (1 << W) - 1);
      step(v, b, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
